bus_arb_rr_gen: RTL and testbench

//  Parametrised next-generation bus generator/arbiter: DRVS drivers share one bus, each sourcing packets from a FWFT FIFO.

---
 rtl/bus_arb_rr_gen_pkg.sv | 27 ++
 rtl/bus_arb_rr_gen_if.sv | 38 +++
 rtl/bus_arb_rr_gen_rr_arbiter.sv | 46 ++++
 rtl/bus_arb_rr_gen.sv | 154 +++++++++++++++
 tb/tb_bus_arb_rr_gen.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arb_rr_gen_pkg.sv
// Package for the bus generator/arbiter.
// Holds the FSM state type, the arbitration mode selectors, the default
// broadcast ID and a helper that extracts the destination ID from a packet.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_e;

  localparam int ARB_RR    = 0;  // round-robin, search starts after last grant
  localparam int ARB_FIXED = 1;  // fixed priority, lowest index wins

  localparam int unsigned BROADCAST_DEF = 32'hFF;

  // Destination ID lives in the top id_w bits of a pckg_sz-bit packet.
  // The packet is passed zero-extended so one function serves every width.
  function automatic logic [31:0] id_of(input logic [63:0] pkt,
                                        input int          pckg_sz,
                                        input int          id_w);
    logic [63:0] shifted;
    shifted = pkt >> (pckg_sz - id_w);
    return 32'(shifted) & ((32'd1 << id_w) - 32'd1);
  endfunction

endpackage

// File: rtl/bus_arb_rr_gen_if.sv
// Interface bundling the per-driver FIFO signals seen by the arbiter.
//   pndng    : driver FIFO i non-empty
//   D_pop    : head-of-FIFO data, DRVS lanes of PCKG_SZ bits
//   pop      : one-hot pop strobe back to the source FIFO
//   full     : receive FIFO i cannot accept a push
//   push     : push strobe(s) to the receive FIFO(s)
//   D_push   : packet data, replicated on every lane
//   busy     : arbiter is handling a packet
//   drop     : one-cycle pulse when a packet is discarded
//   drop_cnt : saturating discarded-packet count
// master = arbiter side, slave = FIFO/environment side.
interface bus_arb_rr_gen_if #(
  parameter int DRVS    = 8,
  parameter int PCKG_SZ = 16,
  parameter int CNT_W   = 16
);

  logic [DRVS-1:0]         pndng;
  logic [DRVS*PCKG_SZ-1:0] D_pop;
  logic [DRVS-1:0]         pop;
  logic [DRVS-1:0]         full;
  logic [DRVS-1:0]         push;
  logic [DRVS*PCKG_SZ-1:0] D_push;
  logic                    busy;
  logic                    drop;
  logic [CNT_W-1:0]        drop_cnt;

  modport master (
    input  pndng, D_pop, full,
    output pop, push, D_push, busy, drop, drop_cnt
  );

  modport slave (
    output pndng, D_pop, full,
    input  pop, push, D_push, busy, drop, drop_cnt
  );

endinterface

// File: rtl/bus_arb_rr_gen_rr_arbiter.sv
// Combinational grant selection.
//   req     : request vector, one bit per driver
//   last    : index of the previously granted driver
//   grant   : chosen driver index (valid when any_req)
//   any_req : at least one request present
// MODE ARB_RR searches from last+1 upward, wrapping N-1 -> 0, so every
// requester is reached within N grants. MODE ARB_FIXED ignores last.
module rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int MODE = ARB_RR,
  localparam int GW   = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  output logic [GW-1:0] grant,
  output logic          any_req
);

  int   idx;
  logic found;

  // NOTE: every variable assigned in always_comb gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      if (MODE == ARB_FIXED) begin
        idx = i;
      end else begin
        idx = int'(last) + 1 + i;
        if (idx >= N) idx = idx - N;
      end
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = GW'(idx);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/bus_arb_rr_gen.sv
// Bus generator/arbiter: DRVS drivers share one bus.
//   clk   : bus clock, all state on the rising edge
//   reset : asynchronous, active-low
//   bus   : bus_arb_rr_gen_if.master (FIFO handshakes, data, status)
// Flow: IDLE picks a pending driver and pops its head packet; POP decodes
// the destination and either builds a target mask or discards the packet;
// PUSH waits until every target can accept, then pushes once. Broadcast
// goes to all drivers except the source and is never split across cycles.
module bus_arb_rr_gen
  import bus_arb_pkg::*;
#(
  parameter int          PCKG_SZ   = 16,
  parameter int          DRVS      = 8,
  parameter int          ID_W      = 8,
  parameter int unsigned BROADCAST = BROADCAST_DEF,
  parameter int          ARB_MODE  = ARB_RR,
  parameter int          CNT_W     = 16
) (
  input  logic       clk,
  input  logic       reset,
  bus_arb_rr_gen_if.master bus
);

  localparam int GW = $clog2(DRVS);

  state_e             state_q, state_d;
  logic [PCKG_SZ-1:0] pkt_q, pkt_d;
  logic [GW-1:0]      src_q, src_d;
  logic [GW-1:0]      last_q, last_d;
  logic [DRVS-1:0]    tgt_q, tgt_d;

  // Output registers
  logic [DRVS-1:0]    pop_q, pop_d;
  logic [DRVS-1:0]    push_q, push_d;
  logic [PCKG_SZ-1:0] d_push_q, d_push_d;
  logic               drop_q, drop_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic [GW-1:0]      grant;
  logic               any_req;
  logic [31:0]        dst_id;
  logic [DRVS-1:0]    dst_hot, src_hot;
  logic               is_unicast, is_bcast;

  rr_arbiter #(
    .N    (DRVS),
    .MODE (ARB_MODE)
  ) u_arb (
    .req     (bus.pndng),
    .last    (last_q),
    .grant   (grant),
    .any_req (any_req)
  );

  // Destination decode of the captured packet. A packet addressed to its own
  // source is treated as invalid rather than looped back.
  always_comb begin
    dst_id  = id_of(64'(pkt_q), PCKG_SZ, ID_W);
    dst_hot = '0;
    dst_hot[dst_id[GW-1:0]] = 1'b1;
    src_hot = '0;
    src_hot[src_q] = 1'b1;
    is_unicast = (dst_id < 32'(DRVS)) && (dst_id != 32'(src_q));
    is_bcast   = (dst_id == BROADCAST);
  end

  always_comb begin
    state_d    = state_q;
    pkt_d      = pkt_q;
    src_d      = src_q;
    last_d     = last_q;
    tgt_d      = tgt_q;
    pop_d      = '0;
    push_d     = '0;
    d_push_d   = d_push_q;
    drop_d     = 1'b0;
    drop_cnt_d = drop_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          pkt_d        = bus.D_pop[int'(grant)*PCKG_SZ +: PCKG_SZ];
          src_d        = grant;
          last_d       = grant;
          pop_d[grant] = 1'b1;
          state_d      = POP;
        end
      end
      POP: begin
        if (is_unicast) begin
          tgt_d   = dst_hot;
          state_d = PUSH;
        end else if (is_bcast) begin
          tgt_d   = ~src_hot;
          state_d = PUSH;
        end else begin
          drop_d = 1'b1;
          if (~&drop_cnt_q) drop_cnt_d = drop_cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      PUSH: begin
        // All-or-nothing: a single full target holds the whole packet.
        if ((tgt_q & bus.full) == '0) begin
          push_d   = tgt_q;
          d_push_d = pkt_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pkt_q      <= '0;
      src_q      <= '0;
      last_q     <= GW'(DRVS - 1);
      tgt_q      <= '0;
      pop_q      <= '0;
      push_q     <= '0;
      d_push_q   <= '0;
      drop_q     <= 1'b0;
      busy_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      src_q      <= src_d;
      last_q     <= last_d;
      tgt_q      <= tgt_d;
      pop_q      <= pop_d;
      push_q     <= push_d;
      d_push_q   <= d_push_d;
      drop_q     <= drop_d;
      busy_q     <= busy_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.pop      = pop_q;
  assign bus.push     = push_q;
  assign bus.D_push   = {DRVS{d_push_q}};
  assign bus.drop     = drop_q;
  assign bus.busy     = busy_q;
  assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_arb_rr_gen.sv
// Bench for bus_arb_rr_gen: a round-robin instance checked every cycle
// against a transaction-timeline model, plus a fixed-priority instance
// sharing the same inputs for the priority check.
module tb_bus_arb_rr_gen;

  localparam int DRVS = 8;
  localparam int PSZ  = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  bit   chk_en = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bus_arb_rr_gen_if #(.DRVS(DRVS), .PCKG_SZ(PSZ), .CNT_W(16)) if_rr ();
  bus_arb_rr_gen_if #(.DRVS(DRVS), .PCKG_SZ(PSZ), .CNT_W(16)) if_fx ();

  assign if_fx.pndng = if_rr.pndng;
  assign if_fx.D_pop = if_rr.D_pop;
  assign if_fx.full  = if_rr.full;

  bus_arb_rr_gen #(.PCKG_SZ(PSZ), .DRVS(DRVS), .ID_W(8), .BROADCAST(32'hFF),
                   .ARB_MODE(0), .CNT_W(16))
    dut_rr (.clk(clk), .reset(reset), .bus(if_rr));

  bus_arb_rr_gen #(.PCKG_SZ(PSZ), .DRVS(DRVS), .ID_W(8), .BROADCAST(32'hFF),
                   .ARB_MODE(1), .CNT_W(16))
    dut_fx (.clk(clk), .reset(reset), .bus(if_fx));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Model: tracks each packet as a timeline of edge numbers. A grant at
  // edge n pops after n; a bad destination drops after n+1 and frees the
  // bus at n+2; a good one may push from edge n+2 on, at the first edge
  // where none of its targets is full.
  // ---------------------------------------------------------------------
  int              n, m_last, m_free, m_drop_at, m_wait_from;
  bit              m_wait;
  logic [7:0]      m_mask, e_pop, e_push;
  logic [15:0]     m_pkt, e_data, m_cnt;
  logic            e_drop, e_busy;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      n = 0; m_last = DRVS - 1; m_free = 0; m_drop_at = -1; m_wait = 1'b0;
      m_mask = '0; m_pkt = '0; m_cnt = '0;
      e_pop = '0; e_push = '0; e_drop = 1'b0; e_busy = 1'b0; e_data = '0;
    end else begin
      n++;
      e_pop = '0; e_push = '0; e_drop = 1'b0;
      if (n == m_drop_at) begin
        e_drop = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
      if (m_wait) begin
        if (n >= m_wait_from && (if_rr.full & m_mask) == 8'h00) begin
          e_push = m_mask; e_data = m_pkt; m_wait = 1'b0; m_free = n + 1;
        end
      end else if (n >= m_free && if_rr.pndng != 8'h00) begin
        int g, dst;
        g = -1;
        for (int k = 1; k <= DRVS && g < 0; k++)
          if (if_rr.pndng[(m_last + k) % DRVS]) g = (m_last + k) % DRVS;
        m_last = g;
        e_pop[g] = 1'b1;
        m_pkt = if_rr.D_pop[g*PSZ +: PSZ];
        dst = int'(m_pkt[15:8]);
        if (dst < DRVS && dst != g) begin
          m_mask = 8'(1 << dst); m_wait = 1'b1; m_wait_from = n + 2;
        end else if (dst == 255) begin
          m_mask = ~8'(1 << g); m_wait = 1'b1; m_wait_from = n + 2;
        end else begin
          m_drop_at = n + 1; m_free = n + 2;
        end
      end
      e_busy = (e_pop != 8'h00) || m_wait;
    end
  end

  always @(negedge clk) begin
    if (reset && chk_en) begin
      check("pop",      if_rr.pop,      e_pop);
      check("push",     if_rr.push,     e_push);
      check("drop",     if_rr.drop,     e_drop);
      check("busy",     if_rr.busy,     e_busy);
      check("drop_cnt", if_rr.drop_cnt, m_cnt);
      check("pop_and_push", if_rr.pop & if_rr.push, 8'h00);
      if (e_push != 8'h00) check("d_push", if_rr.D_push, {8{e_data}});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  // Sets driver src pending with pkt and waits for its pop (bounded).
  task automatic send_pkt(input int src, input logic [15:0] pkt, output int lat);
    bit seen;
    seen = 1'b0;
    if_rr.D_pop[src*PSZ +: PSZ] = pkt;
    if_rr.pndng[src] = 1'b1;
    lat = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (if_rr.pop[src]) begin
        seen = 1'b1;
        if_rr.pndng[src] = 1'b0;
      end
    end
    check("pop_seen", seen, 1);
  endtask

  task automatic wait_push(inout int lat);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (if_rr.push != 8'h00) seen = 1'b1;
    end
    check("push_seen", seen, 1);
  endtask

  task automatic load_all_valid();
    for (int i = 0; i < DRVS; i++)
      if_rr.D_pop[i*PSZ +: PSZ] = {8'((i + 1) % DRVS), 8'(i)};
  endtask

  initial begin
    int lat;
    int grants[$];
    int exp_order[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    bit fx_ok;

    if_rr.pndng = '0;
    if_rr.D_pop = '0;
    if_rr.full  = '0;
    repeat (2) @(negedge clk);
    check("rst_pop",      if_rr.pop,      8'h00);
    check("rst_push",     if_rr.push,     8'h00);
    check("rst_busy",     if_rr.busy,     1'b0);
    check("rst_drop",     if_rr.drop,     1'b0);
    check("rst_drop_cnt", if_rr.drop_cnt, 16'h0000);
    check("rst_d_push",   if_rr.D_push,   128'h0);
    reset  = 1'b1;
    chk_en = 1'b1;

    // Single unicast 2 -> 5
    send_pkt(2, 16'h0501, lat);
    check("t1_pop_lat", lat, 1);
    wait_push(lat);
    check("t1_latency", lat, 3);
    check("t1_push",    if_rr.push, 8'h20);
    check("t1_data",    if_rr.D_push[5*PSZ +: PSZ], 16'h0501);
    check("t1_busy",    if_rr.busy, 1'b0);

    // Broadcast from driver 3
    send_pkt(3, 16'hFFAA, lat);
    wait_push(lat);
    check("t3_push", if_rr.push,   8'hF7);
    check("t3_data", if_rr.D_push, {8{16'hFFAA}});
    @(negedge clk);
    check("t3_single", if_rr.push, 8'h00);

    // Backpressure on target 4
    if_rr.full = 8'h10;
    send_pkt(0, 16'h0455, lat);
    repeat (10) begin
      @(negedge clk);
      check("t4_hold_push", if_rr.push, 8'h00);
      check("t4_hold_busy", if_rr.busy, 1'b1);
    end
    if_rr.full = 8'h00;
    @(negedge clk);
    check("t4_push", if_rr.push, 8'h10);
    check("t4_data", if_rr.D_push[4*PSZ +: PSZ], 16'h0455);

    // Invalid ID and self-addressed packet
    send_pkt(1, 16'h2000, lat);
    @(negedge clk);
    check("t5_drop1", if_rr.drop, 1'b1);
    check("t5_push1", if_rr.push, 8'h00);
    send_pkt(1, 16'h0100, lat);
    @(negedge clk);
    check("t5_drop2", if_rr.drop, 1'b1);
    check("t5_push2", if_rr.push, 8'h00);
    check("t5_cnt",   if_rr.drop_cnt, 16'd2);

    // Fairness from a clean reset
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    load_all_valid();
    if_rr.pndng = 8'hFF;
    fx_ok = 1'b1;
    for (int c = 0; c < 60 && grants.size() < 9; c++) begin
      @(negedge clk);
      for (int i = 0; i < DRVS; i++)
        if (if_rr.pop[i]) grants.push_back(i);
      if (if_fx.pop != 8'h00 && if_fx.pop != 8'h01) fx_ok = 1'b0;
    end
    check("t2_grant_count", grants.size(), 9);
    for (int i = 0; i < 9 && i < grants.size(); i++)
      check("t2_rr_order", grants[i], exp_order[i]);
    check("t2_fixed_prio", fx_ok, 1'b1);

    // Reset while holding in PUSH
    if_rr.pndng = 8'h00;
    repeat (8) @(negedge clk);
    if_rr.full = 8'h10;
    send_pkt(0, 16'h0433, lat);
    repeat (3) @(negedge clk);
    check("t6_busy_before", if_rr.busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("t6_pop",  if_rr.pop,      8'h00);
    check("t6_push", if_rr.push,     8'h00);
    check("t6_busy", if_rr.busy,     1'b0);
    check("t6_drop", if_rr.drop,     1'b0);
    check("t6_cnt",  if_rr.drop_cnt, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    if_rr.full = 8'h00;
    load_all_valid();
    if_rr.pndng = 8'hFF;
    @(negedge clk);
    check("t6_first_grant", if_rr.pop, 8'h01);
    if_rr.pndng = 8'h00;
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
